// File: rtl/pocket_detector_if.sv
// Signal bundle between the pixel scanner / game logic and the pocket detector.
// The detector sits on the slave side; the scanner and game logic drive the master side.
interface pocket_detector_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        drawingRequestBall;
    logic        drawingRequestHole;
    logic        clearHole;
    logic [2:0]  holeNumber;
    logic        holeValid;
    logic        holeEvent;

    modport master (
        output startOfFrame, pixelX, pixelY, drawingRequestBall, drawingRequestHole, clearHole,
        input  holeNumber, holeValid, holeEvent
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, drawingRequestBall, drawingRequestHole, clearHole,
        output holeNumber, holeValid, holeEvent
    );
endinterface

// File: rtl/pocket_detector.sv
// Finds which of the six table pockets the ball fell into: the first ball/hole overlap of each frame
// is classified by table geometry and must repeat on the same pocket over consecutive frames.
module pocket_detector #(
    parameter int TOP_OFFSET     = 0,
    parameter int DOWN_OFFSET    = 479,
    parameter int LEFT_OFFSET    = 0,
    parameter int RIGHT_OFFSET   = 639,
    parameter int CONFIRM_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    pocket_detector_if.slave bus
);
    localparam int          MID_COL        = (LEFT_OFFSET + RIGHT_OFFSET) / 2;
    localparam logic [10:0] SPLIT_LEFT     = 11'((LEFT_OFFSET + MID_COL) / 2);
    localparam logic [10:0] SPLIT_RIGHT    = 11'((MID_COL + RIGHT_OFFSET) / 2);
    localparam logic [10:0] SPLIT_ROW      = 11'((TOP_OFFSET + DOWN_OFFSET) / 2);
    localparam logic [2:0]  CONFIRM_TARGET = 3'(CONFIRM_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM,
        LATCHED
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  count_q, count_d;
    logic        frameHit_q, frameHit_d;
    logic [2:0]  frameHole_q, frameHole_d;
    logic        frameArmed_q, frameArmed_d;
    logic [2:0]  holeNumber_q, holeNumber_d;
    logic        holeValid_q, holeValid_d;
    logic        holeEvent_q, holeEvent_d;

    logic [1:0]  colIdx;
    logic        rowTop;
    logic [2:0]  pixelHole;
    logic        hit;
    logic        evaluate;
    logic        enterLatched;

    assign hit      = bus.drawingRequestBall & bus.drawingRequestHole;
    assign evaluate = bus.startOfFrame & frameArmed_q & ~bus.clearHole;

    // Top row counts 1-3 left to right, bottom row counts 4-6 right to left.
    always_comb begin
        colIdx = 2'd2;
        if (bus.pixelX < SPLIT_LEFT) begin
            colIdx = 2'd0;
        end else if (bus.pixelX < SPLIT_RIGHT) begin
            colIdx = 2'd1;
        end
        rowTop = (bus.pixelY < SPLIT_ROW);
        pixelHole = 3'd0;
        case ({rowTop, colIdx})
            3'b100:  pixelHole = 3'd1;
            3'b101:  pixelHole = 3'd2;
            3'b110:  pixelHole = 3'd3;
            3'b010:  pixelHole = 3'd4;
            3'b001:  pixelHole = 3'd5;
            3'b000:  pixelHole = 3'd6;
            default: pixelHole = 3'd0;
        endcase
    end

    // Only the earliest hit in scan order represents the frame; a frame only counts once armed.
    always_comb begin
        frameHit_d   = frameHit_q;
        frameHole_d  = frameHole_q;
        frameArmed_d = frameArmed_q;
        if (bus.clearHole) begin
            frameHit_d   = 1'b0;
            frameHole_d  = 3'd0;
            frameArmed_d = bus.startOfFrame;
        end else if (bus.startOfFrame) begin
            frameHit_d   = 1'b0;
            frameHole_d  = 3'd0;
            frameArmed_d = 1'b1;
        end else if (hit && !frameHit_q) begin
            frameHit_d  = 1'b1;
            frameHole_d = pixelHole;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        if (bus.clearHole) begin
            state_d = SEARCH;
            count_d = 3'd0;
        end else if (evaluate) begin
            case (state_q)
                SEARCH: begin
                    if (frameHit_q) begin
                        pending_d = frameHole_q;
                        count_d   = 3'd1;
                        state_d   = (CONFIRM_TARGET == 3'd1) ? LATCHED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!frameHit_q) begin
                        count_d = 3'd0;
                        state_d = SEARCH;
                    end else if (frameHole_q == pending_q) begin
                        count_d = count_q + 3'd1;
                        if (count_q + 3'd1 == CONFIRM_TARGET) begin
                            state_d = LATCHED;
                        end
                    end else begin
                        pending_d = frameHole_q;
                        count_d   = 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered, so they follow the deciding startOfFrame by one clock.
    always_comb begin
        enterLatched = (state_d == LATCHED) && (state_q != LATCHED);
        holeNumber_d = holeNumber_q;
        holeValid_d  = holeValid_q;
        holeEvent_d  = 1'b0;
        if (bus.clearHole) begin
            holeNumber_d = 3'd0;
            holeValid_d  = 1'b0;
        end else if (enterLatched) begin
            holeNumber_d = pending_d;
            holeValid_d  = 1'b1;
            holeEvent_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEARCH;
            pending_q    <= 3'd0;
            count_q      <= 3'd0;
            frameHit_q   <= 1'b0;
            frameHole_q  <= 3'd0;
            frameArmed_q <= 1'b0;
            holeNumber_q <= 3'd0;
            holeValid_q  <= 1'b0;
            holeEvent_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            count_q      <= count_d;
            frameHit_q   <= frameHit_d;
            frameHole_q  <= frameHole_d;
            frameArmed_q <= frameArmed_d;
            holeNumber_q <= holeNumber_d;
            holeValid_q  <= holeValid_d;
            holeEvent_q  <= holeEvent_d;
        end
    end

    assign bus.holeNumber = holeNumber_q;
    assign bus.holeValid  = holeValid_q;
    assign bus.holeEvent  = holeEvent_q;
endmodule

// File: tb/tb_pocket_detector.sv
// Bench for pocket_detector: directed frame scenarios plus random frames, checked against a
// run-length model of consecutive per-frame pocket hits.
module tb_pocket_detector;
    localparam int TOP = 0, DOWN = 479, LEFT = 0, RIGHT = 639, CF = 2;
    localparam int MID = (LEFT + RIGHT) / 2;
    localparam int SPLIT_L = (LEFT + MID) / 2;
    localparam int SPLIT_R = (MID + RIGHT) / 2;
    localparam int SPLIT_ROW = (TOP + DOWN) / 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nChecks = 0;
    int   nFails = 0;
    int   seenEvents = 0;

    // Reference model: armed flag, first pocket hit of the current frame, current run, latched pocket.
    bit       mArmed = 0;
    int       mFirst = 0;
    int       mRunHole = 0;
    int       mRunLen = 0;
    int       mLatched = 0;
    bit       mEvent = 0;
    int       mEvents = 0;

    pocket_detector_if bus ();

    pocket_detector #(
        .TOP_OFFSET(TOP), .DOWN_OFFSET(DOWN), .LEFT_OFFSET(LEFT),
        .RIGHT_OFFSET(RIGHT), .CONFIRM_FRAMES(CF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.holeEvent === 1'b1) seenEvents++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int classify(input logic [10:0] x, input logic [10:0] y);
        int col = (int'(x) < SPLIT_L) ? 0 : (int'(x) < SPLIT_R) ? 1 : 2;
        return (int'(y) < SPLIT_ROW) ? col + 1 : 6 - col;
    endfunction

    task automatic holeCoord(input int h, output logic [10:0] x, output logic [10:0] y);
        int xl, xh;
        if (h == 1 || h == 6) begin xl = LEFT; xh = SPLIT_L - 1; end
        else if (h == 2 || h == 5) begin xl = SPLIT_L; xh = SPLIT_R - 1; end
        else begin xl = SPLIT_R; xh = RIGHT; end
        x = 11'($urandom_range(xh, xl));
        y = (h <= 3) ? 11'($urandom_range(SPLIT_ROW - 1, TOP)) : 11'($urandom_range(DOWN, SPLIT_ROW));
    endtask

    task automatic tick(input logic sof, input logic clr, input logic ball, input logic hole,
                        input logic [10:0] x, input logic [10:0] y);
        bus.startOfFrame = sof;
        bus.clearHole = clr;
        bus.drawingRequestBall = ball;
        bus.drawingRequestHole = hole;
        bus.pixelX = x;
        bus.pixelY = y;
        @(posedge clk);
        mEvent = 0;
        if (reset) begin
            mArmed = 0; mFirst = 0; mRunHole = 0; mRunLen = 0; mLatched = 0;
        end else if (clr) begin
            mLatched = 0; mRunLen = 0; mFirst = 0; mArmed = sof;
        end else if (sof) begin
            if (mArmed && mLatched == 0) begin
                if (mFirst == 0) mRunLen = 0;
                else if (mFirst == mRunHole && mRunLen > 0) mRunLen++;
                else begin mRunHole = mFirst; mRunLen = 1; end
                if (mRunLen == CF) begin
                    mLatched = mRunHole; mRunLen = 0; mEvent = 1; mEvents++;
                end
            end
            mArmed = 1;
            mFirst = 0;
        end else if (ball && hole && mFirst == 0) begin
            mFirst = classify(x, y);
        end
        #1;
    endtask

    task automatic sofTick(input logic clr);
        tick(1'b1, clr, 1'b0, 1'b0, 11'd0, 11'd0);
    endtask

    task automatic idleTick();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    endtask

    // One frame body of 8 pixels; overlaps A and B land on pixels 2 and 5, the rest are single requests.
    task automatic pixels(input logic [10:0] xa, input logic [10:0] ya, input logic ha,
                          input logic [10:0] xb, input logic [10:0] yb, input logic hb);
        int r;
        for (int i = 0; i < 8; i++) begin
            if (i == 2 && ha) tick(1'b0, 1'b0, 1'b1, 1'b1, xa, ya);
            else if (i == 5 && hb) tick(1'b0, 1'b0, 1'b1, 1'b1, xb, yb);
            else begin
                r = int'($urandom_range(2, 0));
                tick(1'b0, 1'b0, r == 1, r == 2, 11'($urandom_range(RIGHT, 0)), 11'($urandom_range(DOWN, 0)));
            end
        end
    endtask

    task automatic hitFrame(input logic [10:0] x, input logic [10:0] y);
        pixels(x, y, 1'b1, 11'd0, 11'd0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 11'd5, 11'd5);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 11'd5, 11'd5);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++; if (bus.holeNumber !== 3'd0) begin nFails++; $display("[TB] FAIL reset_holeNumber: got %0d, expected 0", bus.holeNumber); end
        nChecks++; if (bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_holeValid: got %b, expected 0", bus.holeValid); end
        nChecks++; if (bus.holeEvent !== 1'b0) begin nFails++; $display("[TB] FAIL reset_holeEvent: got %b, expected 0", bus.holeEvent); end
    endtask

    task automatic test_idle_frames();
        int startSeen = seenEvents;
        sofTick(1'b0);
        repeat (4) begin
            pixels(11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 1'b0);
            sofTick(1'b0);
        end
        idleTick();
        nChecks++; if (bus.holeValid !== 1'b0 || bus.holeNumber !== 3'd0) begin nFails++; $display("[TB] FAIL idle_outputs: got valid=%b number=%0d, expected valid=0 number=0", bus.holeValid, bus.holeNumber); end
        nChecks++; if (seenEvents - startSeen !== 0) begin nFails++; $display("[TB] FAIL idle_events: got %0d events, expected 0", seenEvents - startSeen); end
    endtask

    task automatic test_confirm_tl();
        doReset();
        sofTick(1'b0);
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL tl_early_valid: got %b, expected 0", bus.holeValid); end
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeEvent !== 1'b1) begin nFails++; $display("[TB] FAIL tl_event: got %b, expected 1", bus.holeEvent); end
        nChecks++; if (bus.holeNumber !== 3'd1 || bus.holeValid !== 1'b1) begin nFails++; $display("[TB] FAIL tl_latched: got number=%0d valid=%b, expected number=1 valid=1", bus.holeNumber, bus.holeValid); end
        idleTick();
        nChecks++; if (bus.holeEvent !== 1'b0) begin nFails++; $display("[TB] FAIL tl_event_width: got %b, expected 0", bus.holeEvent); end
        nChecks++; if (bus.holeNumber !== 3'd1 || bus.holeValid !== 1'b1) begin nFails++; $display("[TB] FAIL tl_hold: got number=%0d valid=%b, expected number=1 valid=1", bus.holeNumber, bus.holeValid); end
    endtask

    task automatic test_candidate_switch();
        int startSeen;
        doReset();
        startSeen = seenEvents;
        sofTick(1'b0);
        hitFrame(11'd320, 11'd470);
        sofTick(1'b0);
        hitFrame(11'd630, 11'd470);
        sofTick(1'b0);
        nChecks++; if (bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL switch_early_valid: got %b, expected 0", bus.holeValid); end
        hitFrame(11'd630, 11'd470);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'd4 || bus.holeEvent !== 1'b1) begin nFails++; $display("[TB] FAIL switch_number: got number=%0d event=%b, expected number=4 event=1", bus.holeNumber, bus.holeEvent); end
        idleTick();
        nChecks++; if (seenEvents - startSeen !== 1) begin nFails++; $display("[TB] FAIL switch_event_count: got %0d, expected 1", seenEvents - startSeen); end
    endtask

    task automatic test_scan_priority();
        doReset();
        sofTick(1'b0);
        pixels(11'd320, 11'd5, 1'b1, 11'd630, 11'd470, 1'b1);
        sofTick(1'b0);
        pixels(11'd320, 11'd5, 1'b1, 11'd630, 11'd470, 1'b1);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'd2 || bus.holeValid !== 1'b1) begin nFails++; $display("[TB] FAIL priority_number: got number=%0d valid=%b, expected number=2 valid=1", bus.holeNumber, bus.holeValid); end
        idleTick();
    endtask

    task automatic test_gap_restart();
        doReset();
        sofTick(1'b0);
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        pixels(11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 1'b0);
        sofTick(1'b0);
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeValid !== 1'b0 || bus.holeEvent !== 1'b0) begin nFails++; $display("[TB] FAIL gap_no_report: got valid=%b event=%b, expected 0 0", bus.holeValid, bus.holeEvent); end
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'd1 || bus.holeEvent !== 1'b1) begin nFails++; $display("[TB] FAIL gap_restart: got number=%0d event=%b, expected number=1 event=1", bus.holeNumber, bus.holeEvent); end
        idleTick();
    endtask

    task automatic test_clear();
        doReset();
        sofTick(1'b0);
        hitFrame(11'd5, 11'd470);
        sofTick(1'b0);
        hitFrame(11'd5, 11'd470);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'd6) begin nFails++; $display("[TB] FAIL clear_setup: got %0d, expected 6", bus.holeNumber); end
        hitFrame(11'd5, 11'd5);
        sofTick(1'b1);
        nChecks++; if (bus.holeNumber !== 3'd0 || bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL clear_sof: got number=%0d valid=%b, expected 0 0", bus.holeNumber, bus.holeValid); end
        hitFrame(11'd630, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL clear_first_frame: got %b, expected 0", bus.holeValid); end
        hitFrame(11'd630, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'(mLatched) || bus.holeEvent !== 1'b1) begin nFails++; $display("[TB] FAIL clear_relatch: got number=%0d event=%b, expected number=%0d event=1", bus.holeNumber, bus.holeEvent, mLatched); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0);
        nChecks++; if (bus.holeEvent !== 1'b0 || bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL clear_during_event: got event=%b valid=%b, expected 0 0", bus.holeEvent, bus.holeValid); end
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL clear_partial_discard: got %b, expected 0", bus.holeValid); end
        hitFrame(11'd5, 11'd5);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'd1) begin nFails++; $display("[TB] FAIL clear_after_rearm: got %0d, expected 1", bus.holeNumber); end
        idleTick();
    endtask

    task automatic test_reset_mid_confirm();
        doReset();
        sofTick(1'b0);
        hitFrame(11'd630, 11'd470);
        sofTick(1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 11'd630, 11'd470);
        reset = 1'b1;
        idleTick();
        reset = 1'b0;
        nChecks++; if (bus.holeNumber !== 3'd0 || bus.holeValid !== 1'b0 || bus.holeEvent !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_outputs: got number=%0d valid=%b event=%b, expected all 0", bus.holeNumber, bus.holeValid, bus.holeEvent); end
        hitFrame(11'd630, 11'd470);
        sofTick(1'b0);
        hitFrame(11'd630, 11'd470);
        sofTick(1'b0);
        nChecks++; if (bus.holeValid !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_count: got %b, expected 0", bus.holeValid); end
        hitFrame(11'd630, 11'd470);
        sofTick(1'b0);
        nChecks++; if (bus.holeNumber !== 3'd4) begin nFails++; $display("[TB] FAIL midreset_latch: got %0d, expected 4", bus.holeNumber); end
        idleTick();
    endtask

    task automatic test_random();
        int         prevHole = 1;
        int         h;
        logic [10:0] xa, ya, xb, yb;
        logic       ha, hb, clr;
        doReset();
        sofTick(1'b0);
        for (int f = 0; f < 40; f++) begin
            ha = ($urandom_range(9, 0) >= 2);
            h = ($urandom_range(9, 0) < 6) ? prevHole : int'($urandom_range(6, 1));
            prevHole = h;
            holeCoord(h, xa, ya);
            hb = ($urandom_range(3, 0) == 0);
            holeCoord(int'($urandom_range(6, 1)), xb, yb);
            if (mLatched != 0 && $urandom_range(3, 0) == 0) tick(1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0);
            pixels(xa, ya, ha, xb, yb, hb);
            clr = (mLatched != 0) && ($urandom_range(3, 0) == 0);
            sofTick(clr);
            nChecks++; if (bus.holeNumber !== 3'(mLatched)) begin nFails++; $display("[TB] FAIL random_number frame %0d: got %0d, expected %0d", f, bus.holeNumber, mLatched); end
            nChecks++; if (bus.holeValid !== (mLatched != 0)) begin nFails++; $display("[TB] FAIL random_valid frame %0d: got %b, expected %b", f, bus.holeValid, mLatched != 0); end
            nChecks++; if (bus.holeEvent !== mEvent) begin nFails++; $display("[TB] FAIL random_event frame %0d: got %b, expected %b", f, bus.holeEvent, mEvent); end
        end
        idleTick();
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.clearHole = 1'b0;
        bus.drawingRequestBall = 1'b0;
        bus.drawingRequestHole = 1'b0;
        bus.pixelX = 11'd0;
        bus.pixelY = 11'd0;
        test_reset();
        test_idle_frames();
        test_confirm_tl();
        test_candidate_switch();
        test_scan_priority();
        test_gap_restart();
        test_clear();
        test_reset_mid_confirm();
        test_random();
        idleTick();
        nChecks++; if (seenEvents !== mEvents) begin nFails++; $display("[TB] FAIL total_events: got %0d, expected %0d", seenEvents, mEvents); end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
